main_decoder: RTL and testbench
===============================

MAIN_DECODER -- requirements
Module: main_decoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock, used only by the status register.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 op  input  7  RV32I opcode field (instr[6:0]).
REQ-006 RegWrite  output  1  register-file write enable.
REQ-007 ImmSrc  output  2  immediate format select: 00 I, 01 S, 10 B, 11 J.
REQ-008 ALUSrc  output  2  ALU operand B select: 00 rs2, 01 immediate; 10 and 11 are reserved and never driven.
REQ-009 MemWrite  output  1  data-memory write enable.
REQ-010 ResultSrc  output  2  writeback select: 00 ALU, 01 memory, 10 PC+4; 11 is reserved and never driven.
REQ-011 branch  output  1  conditional-branch instruction.
REQ-012 ALUOp  output  2  ALU decode class: 00 add, 01 subtract/compare, 10 funct-decoded.
REQ-013 jump  output  1  unconditional jump (JAL).
REQ-014 illegal_op  output  1  sticky flag: an unsupported opcode has been decoded since the last reset.

Function
REQ-015 The decode outputs SHALL be a purely combinational function of op and rst, with zero-cycle latency.
REQ-016 op=0000011 (load) SHALL drive RegWrite=1, ImmSrc=00, ALUSrc=01, MemWrite=0, ResultSrc=01, branch=0, ALUOp=00, jump=0.
REQ-017 op=0100011 (store) SHALL drive RegWrite=0, ImmSrc=01, ALUSrc=01, MemWrite=1, ResultSrc=00, branch=0, ALUOp=00, jump=0.
REQ-018 op=0110011 (R-type) SHALL drive RegWrite=1, ImmSrc=00, ALUSrc=00, MemWrite=0, ResultSrc=00, branch=0, ALUOp=10, jump=0.
REQ-019 op=1100011 (branch) SHALL drive RegWrite=0, ImmSrc=10, ALUSrc=00, MemWrite=0, ResultSrc=00, branch=1, ALUOp=01, jump=0.
REQ-020 op=0010011 (I-type ALU) SHALL drive RegWrite=1, ImmSrc=00, ALUSrc=01, MemWrite=0, ResultSrc=00, branch=0, ALUOp=10, jump=0.
REQ-021 op=1101111 (JAL) SHALL drive RegWrite=1, ImmSrc=11, ALUSrc=00, MemWrite=0, ResultSrc=10, branch=0, ALUOp=00, jump=1.
REQ-022 Any other op value, including X/Z-free values such as 0000000 and 1111111, SHALL drive every decode output to 0.
REQ-023 At most one of branch, jump and MemWrite SHALL be 1 at any time.
REQ-024 MemWrite and RegWrite SHALL never both be 1.
REQ-025 On each rising clk edge with rst=0 and an unsupported op, illegal_op SHALL become 1 and SHALL hold 1 until reset.
REQ-026 A supported op SHALL NOT clear illegal_op.

Reset
REQ-027 While rst=1, all decode outputs SHALL be forced to 0 combinationally, regardless of op.
REQ-028 A rising clk edge with rst=1 SHALL clear illegal_op to 0, even if op is unsupported in that cycle.
REQ-029 When rst deasserts mid-stream, decode SHALL resume on the next op with no extra cycle.

Structure
REQ-030 Opcode constants SHALL live in a shared package: OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL.
REQ-031 The same package SHALL hold the encoding constants for ImmSrc, ALUSrc, ResultSrc and ALUOp.
REQ-032 The decode table SHALL be a single case statement with a default arm, in one module; no sub-module is required.

Verification
REQ-033 rst=0, op=0000011 -> RegWrite=1, ImmSrc=00, ALUSrc=01, MemWrite=0, ResultSrc=01, branch=0, ALUOp=00, jump=0.
REQ-034 Apply each of 0100011, 0110011, 1100011, 0010011, 1101111 for 5 ns each -> outputs match REQ-017 to REQ-021 exactly.
REQ-035 rst=1 with op=0110011 -> all decode outputs are 0; deassert rst -> RegWrite=1, ALUOp=10 with no delay.
REQ-036 rst=0, op=1111111, one clk edge -> all decode outputs are 0 and illegal_op=1; then op=0110011 for 3 edges -> illegal_op stays 1.
REQ-037 illegal_op=1, rst=1 for one edge with op=1111111 -> illegal_op=0.
REQ-038 Sweep all 128 op values -> REQ-023 and REQ-024 hold for every value, and illegal_op sets only for the 122 unsupported values.

Source files
------------

// File: rtl/main_decoder_pkg.sv
// Shared RV32I main-decoder constants: opcodes, control-field encodings, control bundle.
// No latency or flow control; constants and pure functions only.
package main_decoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUSRC_REG = 2'b00;
  localparam logic [1:0] ALUSRC_IMM = 2'b01;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic [1:0] alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
  } ctrl_t;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL: op_supported = 1'b1;
      default:                                                  op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/main_decoder.sv
// RV32I main decoder: opcode -> datapath control, plus sticky unsupported-opcode flag.
// Decode is combinational (0 cycles); illegal_op updates on the next clk edge.
// No backpressure: op is consumed every cycle.
module main_decoder
  import main_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrc,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic       branch,
  output logic [1:0] ALUOp,
  output logic       jump,
  output logic       illegal_op
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    // Reset masks decode so nothing writes state while the core is held.
    if (!rst) begin
      case (op)
        OP_LOAD: begin
          ctrl.reg_write  = 1'b1;
          ctrl.imm_src    = IMM_I;
          ctrl.alu_src    = ALUSRC_IMM;
          ctrl.result_src = RES_MEM;
          ctrl.alu_op     = ALUOP_ADD;
        end
        OP_STORE: begin
          ctrl.imm_src    = IMM_S;
          ctrl.alu_src    = ALUSRC_IMM;
          ctrl.mem_write  = 1'b1;
          ctrl.result_src = RES_ALU;
          ctrl.alu_op     = ALUOP_ADD;
        end
        OP_RTYPE: begin
          ctrl.reg_write  = 1'b1;
          ctrl.alu_src    = ALUSRC_REG;
          ctrl.result_src = RES_ALU;
          ctrl.alu_op     = ALUOP_FUNCT;
        end
        OP_BRANCH: begin
          ctrl.imm_src    = IMM_B;
          ctrl.alu_src    = ALUSRC_REG;
          ctrl.branch     = 1'b1;
          ctrl.alu_op     = ALUOP_SUB;
        end
        OP_ITYPE: begin
          ctrl.reg_write  = 1'b1;
          ctrl.imm_src    = IMM_I;
          ctrl.alu_src    = ALUSRC_IMM;
          ctrl.result_src = RES_ALU;
          ctrl.alu_op     = ALUOP_FUNCT;
        end
        OP_JAL: begin
          ctrl.reg_write  = 1'b1;
          ctrl.imm_src    = IMM_J;
          ctrl.alu_src    = ALUSRC_REG;
          ctrl.result_src = RES_PC4;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.jump       = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign RegWrite  = ctrl.reg_write;
  assign ImmSrc    = ctrl.imm_src;
  assign ALUSrc    = ctrl.alu_src;
  assign MemWrite  = ctrl.mem_write;
  assign ResultSrc = ctrl.result_src;
  assign branch    = ctrl.branch;
  assign ALUOp     = ctrl.alu_op;
  assign jump      = ctrl.jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else if (!op_supported(op)) begin
      illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_main_decoder.sv
// Randomized and directed checks of main_decoder against a table-driven reference model.
module tb_main_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       RegWrite, MemWrite, branch, jump, illegal_op;
  logic [1:0] ImmSrc, ALUSrc, ResultSrc, ALUOp;

  int tests  = 0;
  int errors = 0;

  // Expected control word {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, branch, ALUOp, jump}
  logic [11:0] exp_tab [logic [6:0]];
  logic [6:0]  legal_ops [6];
  logic        m_ill;

  main_decoder dut (
    .clk(clk), .rst(rst), .op(op),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .branch(branch), .ALUOp(ALUOp), .jump(jump),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  wire [11:0] dec = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, branch, ALUOp, jump};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (op=%b rst=%b)", tag, got, exp, op, rst);
    end
  endtask

  function automatic logic [11:0] model_dec(input logic [6:0] o, input logic r);
    if (r || !exp_tab.exists(o)) return 12'h000;
    return exp_tab[o];
  endfunction

  // Advance one edge, track the sticky flag in the model, leave time 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) m_ill = 1'b0;
    else if (!exp_tab.exists(op)) m_ill = 1'b1;
    #1;
  endtask

  task automatic check_invariants(input string tag);
    check({tag, "_onehot"}, 32'($countones({branch, jump, MemWrite}) <= 1), 32'd1);
    check({tag, "_memreg"}, 32'(MemWrite && RegWrite), 32'd0);
  endtask

  initial begin
    exp_tab[7'b0000011] = 12'b1_00_01_0_01_0_00_0;
    exp_tab[7'b0100011] = 12'b0_01_01_1_00_0_00_0;
    exp_tab[7'b0110011] = 12'b1_00_00_0_00_0_10_0;
    exp_tab[7'b1100011] = 12'b0_10_00_0_00_1_01_0;
    exp_tab[7'b0010011] = 12'b1_00_01_0_00_0_10_0;
    exp_tab[7'b1101111] = 12'b1_11_00_0_10_0_00_1;
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111};
    m_ill = 1'b0;

    // Reset state with an unsupported opcode present
    rst = 1'b1;
    op  = 7'b1111111;
    tick();
    tick();
    check("reset_dec", 32'(dec), 32'd0);
    check("reset_ill", 32'(illegal_op), 32'd0);

    // Load, then each remaining class held for 5 ns
    rst = 1'b0;
    op  = 7'b0000011;
    #1;
    check("load", 32'(dec), 32'(model_dec(op, rst)));
    for (int i = 1; i < 6; i++) begin
      op = legal_ops[i];
      #5;
      check($sformatf("class_%b", op), 32'(dec), 32'(model_dec(op, rst)));
    end

    // Reset masking and zero-delay resume
    tick();
    rst = 1'b1;
    op  = 7'b0110011;
    #1;
    check("rst_mask", 32'(dec), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_resume_regwrite", 32'(RegWrite), 32'd1);
    check("rst_resume_aluop", 32'(ALUOp), 32'd2);

    // Sticky flag set by 1111111, held through supported ops
    tick();
    op = 7'b1111111;
    #1;
    check("ill_op_dec", 32'(dec), 32'd0);
    tick();
    check("ill_set", 32'(illegal_op), 32'd1);
    op = 7'b0110011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ill_hold", 32'(illegal_op), 32'd1);
    end

    // Reset clears the flag even with an unsupported op
    rst = 1'b1;
    op  = 7'b1111111;
    tick();
    check("ill_clear", 32'(illegal_op), 32'd0);
    rst = 1'b0;

    // Exhaustive sweep, flag cleared before each opcode
    for (int v = 0; v < 128; v++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      op  = 7'(v);
      #1;
      check($sformatf("sweep_dec_%0d", v), 32'(dec), 32'(model_dec(op, 1'b0)));
      check_invariants("sweep");
      tick();
      check($sformatf("sweep_ill_%0d", v), 32'(illegal_op), 32'(!exp_tab.exists(7'(v))));
    end

    // Random opcodes with occasional reset pulses
    rst = 1'b1;
    tick();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) op = legal_ops[$urandom_range(0, 5)];
      else                           op = 7'($urandom);
      #1;
      check("rand_dec", 32'(dec), 32'(model_dec(op, rst)));
      check_invariants("rand");
      tick();
      check("rand_ill", 32'(illegal_op), 32'(m_ill));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
